// File: rtl/regfile_wb_unit_if.sv
// Signal bundle between the EX/MEM result sources, decode and the register file write port.
// The master drives results and issues; the slave is the write-back unit.
interface regfile_wb_unit_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
);
    logic                   flush;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_rd;
    logic                   issue_ready;
    logic [2**ADDR_W-1:0]   busy_vec;
    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   alu_ready;
    logic                   ld_valid;
    logic [ADDR_W-1:0]      ld_rd;
    logic [DATA_W-1:0]      ld_data;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WriteAddr;
    logic [DATA_W-1:0]      WriteData;

    modport master (
        output flush, issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               ld_valid, ld_rd, ld_data,
        input  issue_ready, busy_vec, alu_ready, RegWrite, WriteAddr, WriteData
    );

    modport slave (
        input  flush, issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
               ld_valid, ld_rd, ld_data,
        output issue_ready, busy_vec, alu_ready, RegWrite, WriteAddr, WriteData
    );
endinterface

// File: rtl/regfile_wb_unit.sv
// Register file write-back arbiter: loads take the write port first, ALU results queue in a
// small FIFO, and a per-register busy scoreboard blocks issue of a second write to a pending rd.
module regfile_wb_unit #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              sys_clk,
    input logic              rstn,
    regfile_wb_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2**ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   sel_valid;
    logic   issue_take;
    entry_t head;
    entry_t sel;
    entry_t alu_entry;

    assign fifo_empty      = (count_q == '0);
    assign head            = fifo_mem[rd_ptr_q];
    assign alu_entry.rd    = bus.alu_rd;
    assign alu_entry.data  = bus.alu_data;

    assign bus.alu_ready   = (count_q != FULL_CNT);
    assign bus.issue_ready = !bus.issue_valid || (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
    assign bus.busy_vec    = busy_q;
    assign bus.RegWrite    = reg_write_q;
    assign bus.WriteAddr   = write_addr_q;
    assign bus.WriteData   = write_data_q;

    always_comb begin
        push       = bus.alu_valid && bus.alu_ready && !bus.flush;
        pop        = !bus.ld_valid && !fifo_empty && !bus.flush;
        sel_valid  = (bus.ld_valid || !fifo_empty) && !bus.flush;
        issue_take = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0) && !bus.flush;

        // Loads bypass the FIFO and always win the port.
        sel = head;
        if (bus.ld_valid) begin
            sel.rd   = bus.ld_rd;
            sel.data = bus.ld_data;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Clear on selection first so a same-cycle issue to that rd re-sets it.
        busy_d = busy_q;
        if (sel_valid) begin
            busy_d[sel.rd] = 1'b0;
        end
        if (issue_take) begin
            busy_d[bus.issue_rd] = 1'b1;
        end

        reg_write_d  = sel_valid && (sel.rd != '0);
        write_addr_d = reg_write_d ? sel.rd   : write_addr_q;
        write_data_d = reg_write_d ? sel.data : write_data_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            busy_d   = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rstn && push) begin
            fifo_mem[wr_ptr_q] <= alu_entry;
        end
    end
endmodule

// File: tb/tb_regfile_wb_unit.sv
// Scoreboarded bench for regfile_wb_unit: stimulus queues expected register writes, a monitor
// pops and compares each write presented on the register file port.
module tb_regfile_wb_unit;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    regfile_wb_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wb_unit #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every register write must match the head of the expected queue.
    always @(negedge sys_clk) begin
        wr_t e;
        if (bus.RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got x%0d=%0h, expected no write",
                         bus.WriteAddr, bus.WriteData);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 64'(bus.WriteAddr), 64'(e.rd));
                check("wb_data", bus.WriteData, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd3;
        bus.alu_data    = 64'hDEAD;
        bus.ld_valid    = 1'b1;
        bus.ld_rd       = 5'd4;
        bus.ld_data     = 64'hBEEF;

        // Reset with valids active
        rstn = 1'b0;
        tick();
        tick();
        check("reset_regwrite", 64'(bus.RegWrite), 64'd0);
        check("reset_busy", 64'(bus.busy_vec), 64'd0);
        check("reset_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("reset_waddr", 64'(bus.WriteAddr), 64'd0);
        check("reset_wdata", bus.WriteData, 64'd0);
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.ld_valid    = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // ALU path with latency
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        #1;
        check("issue5_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        check("busy5_set", 64'(bus.busy_vec), 64'h20);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 64'h1234;
        expect_wr(5'd5, 64'h1234);
        tick();
        bus.alu_valid = 1'b0;
        check("alu_lat_n1", 64'(bus.RegWrite), 64'd0);
        check("busy5_held", 64'(bus.busy_vec), 64'h20);
        tick();
        check("alu_lat_n2", 64'(bus.RegWrite), 64'd1);
        check("busy5_clr", 64'(bus.busy_vec), 64'd0);
        tick();

        // Priority: load held 5 cycles while 4 ALU results queue
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd7;
        for (int i = 0; i < 5; i++) begin
            bus.ld_data = 64'h700 + 64'(i);
            expect_wr(5'd7, 64'h700 + 64'(i));
            if (i < 4) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd    = AW'(i + 1);
                bus.alu_data  = 64'hA0 + 64'(i);
                #1;
                check("prio_alu_ready", 64'(bus.alu_ready), 64'd1);
            end else begin
                bus.alu_valid = 1'b0;
                #1;
                check("prio_full", 64'(bus.alu_ready), 64'd0);
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) expect_wr(AW'(i + 1), 64'hA0 + 64'(i));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_consec", 64'(bus.RegWrite), 64'd1);
        end
        tick();
        check("drain_done", 64'(bus.RegWrite), 64'd0);

        // x0: popped without a write; issue rd=0 never sets busy
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = '1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        #1;
        check("x0_issue_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        bus.alu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        check("x0_busy", 64'(bus.busy_vec), 64'd0);
        tick();
        tick();
        check("x0_no_write", 64'(bus.RegWrite), 64'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 64'h33;
        expect_wr(5'd3, 64'h33);
        tick();
        bus.alu_valid = 1'b0;
        check("x0_popped_n1", 64'(bus.RegWrite), 64'd0);
        tick();
        check("x0_popped_n2", 64'(bus.RegWrite), 64'd1);
        tick();

        // Hazard on x9
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        tick();
        check("x9_busy", 64'(bus.busy_vec), 64'h200);
        check("x9_stall", 64'(bus.issue_ready), 64'd0);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd9;
        bus.ld_data  = 64'h99;
        expect_wr(5'd9, 64'h99);
        #1;
        check("x9_stall_ld", 64'(bus.issue_ready), 64'd0);
        tick();
        check("x9_release", 64'(bus.issue_ready), 64'd1);
        check("x9_cleared", 64'(bus.busy_vec), 64'd0);
        bus.ld_data = 64'h9A;
        expect_wr(5'd9, 64'h9A);
        tick();
        bus.ld_valid    = 1'b0;
        bus.issue_valid = 1'b0;
        check("x9_set_wins", 64'(bus.busy_vec), 64'h200);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'h9B;
        expect_wr(5'd9, 64'h9B);
        tick();
        bus.ld_valid = 1'b0;
        check("x9_final_clr", 64'(bus.busy_vec), 64'd0);
        tick();

        // Flush with 3 buffered entries and busy x1, x2
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd1;
        tick();
        bus.issue_rd = 5'd2;
        tick();
        bus.issue_valid = 1'b0;
        check("flush_pre_busy", 64'(bus.busy_vec), 64'h6);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = AW'(i + 1);
            bus.alu_data  = 64'hF0 + 64'(i);
            tick();
        end
        bus.alu_valid   = 1'b0;
        bus.flush       = 1'b1;
        bus.ld_rd       = 5'd6;
        bus.ld_data     = 64'h66;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        tick();
        bus.flush       = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.issue_valid = 1'b0;
        check("flush_busy", 64'(bus.busy_vec), 64'd0);
        check("flush_regwrite", 64'(bus.RegWrite), 64'd0);
        check("flush_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("flush_waddr_hold", 64'(bus.WriteAddr), 64'd9);
        tick();
        tick();
        check("flush_quiet", 64'(bus.RegWrite), 64'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd10;
        bus.alu_data  = 64'hAB;
        expect_wr(5'd10, 64'hAB);
        tick();
        bus.alu_valid = 1'b0;
        check("flush_empty_n1", 64'(bus.RegWrite), 64'd0);
        tick();
        check("flush_empty_n2", 64'(bus.RegWrite), 64'd1);
        tick();

        // Wrap: 10 back-to-back push/pop pairs
        for (int i = 0; i < 10; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = AW'(i + 11);
            bus.alu_data  = 64'hC00 + 64'(i);
            expect_wr(AW'(i + 11), 64'hC00 + 64'(i));
            tick();
        end
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        check("drain_all", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
